// File: rtl/alu_op_sequencer.sv
// Sequences one ALU operation: latch operands, pulse the selected unit's init,
// wait on fixed latency or done handshake (with timeout), then register the result.
module alu_op_sequencer #(
  parameter int unsigned COMB_LAT = 1,
  parameter int unsigned TIMEOUT  = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] opcode,
  input  logic [2:0] portA,
  input  logic [2:0] portB,
  output logic [2:0] op_a,
  output logic [2:0] op_b,
  output logic [3:0] init,
  input  logic [3:0] res_sum,
  input  logic [3:0] res_sub,
  input  logic [5:0] res_mul,
  input  logic [2:0] res_div,
  input  logic       done_mul,
  input  logic       done_div,
  output logic       busy,
  output logic       done,
  output logic [5:0] result,
  output logic       err_div0,
  output logic       err_tmo
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} state_t;

  localparam logic [5:0] CMB_LAST = 6'(COMB_LAT - 1);
  localparam logic [5:0] TMO_LAST = 6'(TIMEOUT - 1);

  state_t     state_q;
  logic [1:0] opc_q;
  logic [5:0] cnt_q;
  logic [2:0] op_a_q, op_b_q;
  logic [3:0] init_q;
  logic       busy_q, done_q, err_div0_q, err_tmo_q;
  logic [5:0] result_q;

  logic       unit_done_d;
  logic [5:0] unit_res_d;

  // Completion condition and width-adjusted result of the unit selected by the latched opcode.
  always_comb begin
    unit_done_d = 1'b0;
    unit_res_d  = '0;
    case (opc_q)
      2'b00: begin
        unit_done_d = (cnt_q == CMB_LAST);
        unit_res_d  = {2'b00, res_sum};
      end
      2'b01: begin
        unit_done_d = (cnt_q == CMB_LAST);
        unit_res_d  = {{2{res_sub[3]}}, res_sub};
      end
      2'b10: begin
        unit_done_d = done_mul;
        unit_res_d  = res_mul;
      end
      default: begin
        unit_done_d = done_div;
        unit_res_d  = {3'b000, res_div};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      opc_q      <= '0;
      cnt_q      <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      init_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      err_div0_q <= 1'b0;
      err_tmo_q  <= 1'b0;
    end else begin
      init_q <= '0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            opc_q      <= opcode;
            op_a_q     <= portA;
            op_b_q     <= portB;
            err_div0_q <= 1'b0;
            err_tmo_q  <= 1'b0;
            busy_q     <= 1'b1;
            if (opcode == 2'b11 && portB == 3'd0) begin
              err_div0_q <= 1'b1;
              result_q   <= '1;
              done_q     <= 1'b1;
              state_q    <= S_DONE;
            end else begin
              init_q  <= 4'b0001 << opcode;
              state_q <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_q + 6'd1;
          // A unit completion in the final timeout cycle takes priority over the abort.
          if (unit_done_d) begin
            result_q <= unit_res_d;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else if ((opc_q[1] == 1'b1) && (cnt_q == TMO_LAST)) begin
            result_q  <= '1;
            err_tmo_q <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign init     = init_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign err_div0 = err_div0_q;
  assign err_tmo  = err_tmo_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: vector table for add/sub/div0,
// hand sequences for handshake, timeout and reset corners, result scoreboard.
module tb_alu_op_sequencer;

  localparam int unsigned COMB_LAT = 1;
  localparam int unsigned TIMEOUT  = 32;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [1:0] opcode;
  logic [2:0] portA, portB, op_a, op_b;
  logic [3:0] init;
  logic [3:0] res_sum, res_sub;
  logic [5:0] res_mul;
  logic [2:0] res_div;
  logic       done_mul, done_div;
  logic       busy, done, err_div0, err_tmo;
  logic [5:0] result;

  always #5 clk = ~clk;

  alu_op_sequencer #(.COMB_LAT(COMB_LAT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .portA(portA), .portB(portB), .op_a(op_a), .op_b(op_b), .init(init),
    .res_sum(res_sum), .res_sub(res_sub), .res_mul(res_mul), .res_div(res_div),
    .done_mul(done_mul), .done_div(done_div), .busy(busy), .done(done),
    .result(result), .err_div0(err_div0), .err_tmo(err_tmo)
  );

  // Behavioural stand-ins for the ALU units.
  assign res_sum = {1'b0, op_a} + {1'b0, op_b};
  assign res_sub = {1'b0, op_a} - {1'b0, op_b};
  assign res_mul = 6'(op_a * op_b);
  assign res_div = (op_b != 3'd0) ? op_a / op_b : 3'd7;

  typedef struct packed {
    logic [5:0] res;
    logic       div0;
    logic       tmo;
  } exp_t;

  typedef struct {
    logic [1:0] op;
    logic [2:0] a;
    logic [2:0] b;
    logic [5:0] res;
    logic       div0;
    logic [3:0] init;
    int         lat;
  } vec_t;

  exp_t sb[$];
  vec_t vt[11];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b);
    start  = 1'b1;
    opcode = op;
    portA  = a;
    portB  = b;
  endtask

  // Completion monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected_done: got done=1 expected no completion");
      end else begin
        e = sb.pop_front();
        n_cmp++;
        if ({result, err_div0, err_tmo} !== {e.res, e.div0, e.tmo}) begin
          n_bad++;
          $display("FAIL sb_result: got res=%0h div0=%0b tmo=%0b expected res=%0h div0=%0b tmo=%0b",
                   result, err_div0, err_tmo, e.res, e.div0, e.tmo);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{2'b00, 3'd3, 3'd4, 6'd7,    1'b0, 4'b0001, 2 + COMB_LAT};
    vt[1]  = '{2'b01, 3'd2, 3'd5, 6'h3D,   1'b0, 4'b0010, 2 + COMB_LAT};
    vt[2]  = '{2'b11, 3'd6, 3'd0, 6'h3F,   1'b1, 4'b0000, 1};
    vt[3]  = '{2'b00, 3'd7, 3'd7, 6'd14,   1'b0, 4'b0001, 2 + COMB_LAT};
    vt[4]  = '{2'b01, 3'd0, 3'd7, 6'h39,   1'b0, 4'b0010, 2 + COMB_LAT};
    vt[5]  = '{2'b00, 3'd0, 3'd0, 6'd0,    1'b0, 4'b0001, 2 + COMB_LAT};
    vt[6]  = '{2'b11, 3'd0, 3'd0, 6'h3F,   1'b1, 4'b0000, 1};
    vt[7]  = '{2'b01, 3'd5, 3'd2, 6'd3,    1'b0, 4'b0010, 2 + COMB_LAT};
    vt[8]  = '{2'b00, 3'd5, 3'd6, 6'd11,   1'b0, 4'b0001, 2 + COMB_LAT};
    vt[9]  = '{2'b01, 3'd7, 3'd0, 6'd7,    1'b0, 4'b0010, 2 + COMB_LAT};
    vt[10] = '{2'b01, 3'd3, 3'd3, 6'd0,    1'b0, 4'b0010, 2 + COMB_LAT};

    rst = 1'b1; start = 1'b0; opcode = '0; portA = '0; portB = '0;
    done_mul = 1'b0; done_div = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("reset_outputs", {busy, done, init, result, err_div0, err_tmo, op_a, op_b}, '0);

    // Table: back-to-back add/sub/div0 with latency, init and operand-latch checks.
    for (int i = 0; i < 11; i++) begin
      sb.push_back('{vt[i].res, vt[i].div0, 1'b0});
      drive_start(vt[i].op, vt[i].a, vt[i].b);
      tick();
      start = 1'b0;
      portA = ~vt[i].a;
      portB = ~vt[i].b;
      cyc = 1;
      check("vec_init", init, vt[i].init);
      check("vec_busy", busy, 1'b1);
      check("vec_ops", {op_a, op_b}, {vt[i].a, vt[i].b});
      while (done !== 1'b1 && cyc < 20) begin
        tick();
        cyc++;
        if (done !== 1'b1) check("vec_init_idle", init, 4'b0000);
      end
      check("vec_latency", cyc, vt[i].lat);
      tick();
    end
    check("idle_busy", busy, 1'b0);

    // Mul 7*7: done_mul raised in cycle 5, completion in cycle 6.
    sb.push_back('{6'd49, 1'b0, 1'b0});
    drive_start(2'b10, 3'd7, 3'd7);
    tick(); start = 1'b0;
    check("mul_init", init, 4'b0100);
    for (int c = 2; c <= 5; c++) begin
      tick();
      check("mul_no_done_early", done, 1'b0);
    end
    done_mul = 1'b1;
    tick();
    done_mul = 1'b0;
    check("mul_done_cycle", done, 1'b1);
    check("mul_result", result, 6'd49);
    tick();

    // Div 6/3 after a divide-by-zero: error flag clears.
    sb.push_back('{6'h3F, 1'b1, 1'b0});
    drive_start(2'b11, 3'd6, 3'd0);
    tick(); start = 1'b0;
    check("div0_no_init", init, 4'b0000);
    check("div0_done", done, 1'b1);
    tick();
    sb.push_back('{6'd2, 1'b0, 1'b0});
    drive_start(2'b11, 3'd6, 3'd3);
    tick(); start = 1'b0;
    check("div_init", init, 4'b1000);
    done_mul = 1'b1;
    tick();
    done_div = 1'b1;
    check("div_ignores_done_mul", done, 1'b0);
    tick();
    done_div = 1'b0; done_mul = 1'b0;
    check("div_done", done, 1'b1);
    check("div_result", {result, err_div0}, {6'd2, 1'b0});
    tick();

    // Mul timeout: 32 WAIT cycles then completion with err_tmo.
    sb.push_back('{6'h3F, 1'b0, 1'b1});
    drive_start(2'b10, 3'd2, 3'd3);
    tick(); start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 60) begin
      tick();
      cyc++;
    end
    check("tmo_latency", cyc, 2 + TIMEOUT);
    check("tmo_flag", err_tmo, 1'b1);
    tick();
    done_mul = 1'b1;
    tick();
    done_mul = 1'b0;
    check("stray_done_mul", done, 1'b0);
    tick();
    check("stray_done_mul_late", done, 1'b0);
    check("tmo_flag_held", err_tmo, 1'b1);

    // Reset in WAIT abandons the operation.
    drive_start(2'b10, 3'd3, 3'd3);
    tick(); start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_outputs", {busy, done, init, result, err_div0, err_tmo, op_a, op_b}, '0);
    tick();
    check("rst_mid_no_done", {busy, done}, 2'b00);

    // Start held through DONE is ignored; still high in IDLE it is accepted.
    sb.push_back('{6'h3F, 1'b1, 1'b0});
    drive_start(2'b11, 3'd6, 3'd0);
    tick();
    check("hold_div0_done", done, 1'b1);
    drive_start(2'b00, 3'd1, 3'd1);
    tick();
    check("hold_ignored_in_done", {busy, init}, 5'b0);
    sb.push_back('{6'd2, 1'b0, 1'b0});
    tick();
    start = 1'b0;
    check("hold_accept_init", init, 4'b0001);
    tick(); tick();
    check("hold_accept_done", done, 1'b1);
    tick(); tick();

    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
